// File: rtl/arf_pkg.sv
// Shared arf definitions: width helpers, count width and serve-state encoding.
// Producer/consumer models and responders import this package.
package arf_pkg;

  localparam int COUNT_W = 32;

  typedef enum logic {ST_IDLE = 1'b0, ST_ACK = 1'b1} serve_state_t;

  // A depth-1 store still needs a 1-bit pointer.
  function automatic int ptr_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Occupancy has to represent 0..n inclusive.
  function automatic int level_w(input int n);
    return $clog2(n) + 1;
  endfunction

endpackage

// File: rtl/arf_push_responder_if.sv
// Push-side (valid/ready) and serve-side (req/ack) bus of the push responder.
interface arf_push_responder_if #(
  parameter int data_width = 32,
  parameter int depth      = 4
);
  logic                    wr_valid;
  logic                    wr_ready;
  logic [data_width-1:0]   wr_data;
  logic                    req;
  logic                    ack;
  logic [data_width-1:0]   dout;
  logic [$clog2(depth):0]  level;
  logic [31:0]             count;

  modport master (
    output wr_valid, wr_data, req,
    input  wr_ready, ack, dout, level, count
  );

  modport slave (
    input  wr_valid, wr_data, req,
    output wr_ready, ack, dout, level, count
  );
endinterface

// File: rtl/arf_fifo_store.sv
// Circular-buffer storage: memory, wrapping pointers and occupancy counter.
// Read data is combinational from rd_ptr; the caller registers it.
module arf_fifo_store
  import arf_pkg::*;
#(
  parameter int data_width = 32,
  parameter int depth      = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wr_en,
  input  logic [data_width-1:0]  wr_data,
  input  logic                   rd_en,
  output logic [data_width-1:0]  rd_data,
  output logic [$clog2(depth):0] level,
  output logic                   full,
  output logic                   empty
);
  localparam int PW = ptr_w(depth);
  localparam int LW = level_w(depth);

  logic [data_width-1:0] mem [depth];
  logic [PW-1:0]         wr_ptr, rd_ptr;

  // Contents are not cleared on reset; level=0 makes them unreachable.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + PW'(1);
      if (rd_en) rd_ptr <= rd_ptr + PW'(1);
      case ({wr_en, rd_en})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

  assign rd_data = mem[rd_ptr];
  assign full    = (level == LW'(depth));
  assign empty   = (level == '0);

endmodule

// File: rtl/arf_push_responder.sv
// Responder end of the arf req/ack handshake, fed by a valid/ready push source.
// Each request is answered with a one-cycle ack and a registered word.
module arf_push_responder
  import arf_pkg::*;
#(
  parameter int data_width = 32,
  parameter int depth      = 4
) (
  input  logic              clk,
  input  logic              rst,
  arf_push_responder_if.slave bus
);
  serve_state_t            state;
  logic                    wr_en, rd_en, full, empty;
  logic [data_width-1:0]   rd_data;
  logic [data_width-1:0]   dout_q;
  logic [COUNT_W-1:0]      count_q;
  logic [$clog2(depth):0]  level;

  // Full blocks the push even if a serve frees a slot on the same edge.
  assign bus.wr_ready = ~full & rst;
  assign wr_en        = bus.wr_valid & bus.wr_ready;
  // Serving only from IDLE keeps a still-high req in the ack cycle from
  // pulling a second word.
  assign rd_en        = bus.req & (state == ST_IDLE) & ~empty;

  arf_fifo_store #(
    .data_width (data_width),
    .depth      (depth)
  ) u_store (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_en),
    .wr_data (bus.wr_data),
    .rd_en   (rd_en),
    .rd_data (rd_data),
    .level   (level),
    .full    (full),
    .empty   (empty)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= ST_IDLE;
      dout_q  <= '0;
      count_q <= '0;
    end else begin
      case (state)
        ST_IDLE: if (rd_en) state <= ST_ACK;
        ST_ACK:  state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
      if (rd_en) begin
        dout_q  <= rd_data;
        count_q <= count_q + COUNT_W'(1);
      end
    end
  end

  assign bus.ack   = (state == ST_ACK);
  assign bus.dout  = dout_q;
  assign bus.count = count_q;
  assign bus.level = level;

endmodule

// File: tb/tb_arf_push_responder.sv
// Randomized and directed bench for arf_push_responder against a queue model.
module tb_arf_push_responder;
  localparam int DW = 32;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_fail   = 0;

  arf_push_responder_if #(.data_width(DW), .depth(DEPTH)) bus();

  arf_push_responder #(.data_width(DW), .depth(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Reference model: stored words, pending ack flag, last served word, ack total.
  logic [DW-1:0] m_q[$];
  logic          m_ack;
  logic [DW-1:0] m_dout;
  logic [31:0]   m_count;

  task automatic model_clear();
    m_q.delete();
    m_ack   = 1'b0;
    m_dout  = '0;
    m_count = '0;
  endtask

  // Drive one cycle of inputs, advance the model over the edge, sample 1 time unit later.
  task automatic cycle(input logic v, input logic [DW-1:0] d, input logic r);
    int  sz;
    bit  serve, push;
    bus.wr_valid = v;
    bus.wr_data  = d;
    bus.req      = r;
    sz    = m_q.size();
    serve = r && !m_ack && (sz != 0);
    push  = v && (sz < DEPTH);
    @(posedge clk);
    if (serve) begin
      m_dout = m_q.pop_front();
      m_count++;
    end
    m_ack = serve;
    if (push) m_q.push_back(d);
    #1;
  endtask

  task automatic do_reset();
    bus.wr_valid = 1'b0;
    bus.wr_data  = '0;
    bus.req      = 1'b0;
    rst = 1'b0;
    model_clear();
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++;
    if (bus.wr_ready !== 1'b1) begin n_fail++; $display("FAIL reset_wr_ready_after_release got %0b want 1", bus.wr_ready); end
    for (int i = 1; i <= 4; i++) cycle(1'b1, DW'(i), 1'b0);
    cycle(1'b0, '0, 1'b1);
    n_checks++;
    if (bus.ack !== 1'b1 || bus.level !== 3) begin n_fail++; $display("FAIL reset_pre_ack got ack=%0b level=%0d want ack=1 level=3", bus.ack, bus.level); end
    #2;
    rst = 1'b0;
    model_clear();
    #1;
    n_checks++;
    if (bus.ack !== 1'b0 || bus.level !== 0 || bus.count !== 0 || bus.dout !== 0 || bus.wr_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_async got ack=%0b level=%0d count=%0d dout=%h wr_ready=%0b want all 0", bus.ack, bus.level, bus.count, bus.dout, bus.wr_ready);
    end
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    n_checks++;
    if (bus.wr_ready !== 1'b1) begin n_fail++; $display("FAIL reset_release_wr_ready got %0b want 1", bus.wr_ready); end
    for (int i = 0; i < 5; i++) begin
      cycle(1'b0, '0, 1'b1);
      n_checks++;
      if (bus.ack !== 1'b0) begin n_fail++; $display("FAIL reset_no_stale_ack cycle %0d got %0b want 0", i, bus.ack); end
    end
    bus.req = 1'b0;
  endtask

  task automatic test_single();
    do_reset();
    for (int i = 0; i < 3; i++) cycle(1'b0, '0, 1'b1);
    cycle(1'b1, 32'h0000_00A5, 1'b1);
    n_checks++;
    if (bus.ack !== 1'b0 || bus.level !== 1) begin n_fail++; $display("FAIL single_no_bypass got ack=%0b level=%0d want ack=0 level=1", bus.ack, bus.level); end
    cycle(1'b0, '0, 1'b1);
    n_checks++;
    if (bus.ack !== 1'b1 || bus.dout !== 32'hA5 || bus.count !== 1 || bus.level !== 0) begin
      n_fail++;
      $display("FAIL single_ack got ack=%0b dout=%h count=%0d level=%0d want 1 a5 1 0", bus.ack, bus.dout, bus.count, bus.level);
    end
    cycle(1'b0, '0, 1'b1);
    n_checks++;
    if (bus.ack !== 1'b0 || bus.dout !== 32'hA5) begin n_fail++; $display("FAIL single_one_pulse got ack=%0b dout=%h want 0 a5", bus.ack, bus.dout); end
  endtask

  task automatic test_full();
    do_reset();
    for (int i = 1; i <= 4; i++) cycle(1'b1, DW'(i), 1'b0);
    n_checks++;
    if (bus.level !== 4 || bus.wr_ready !== 1'b0) begin n_fail++; $display("FAIL full_level got level=%0d wr_ready=%0b want 4 0", bus.level, bus.wr_ready); end
    cycle(1'b1, 32'd5, 1'b0);
    n_checks++;
    if (bus.level !== 4) begin n_fail++; $display("FAIL full_reject got level=%0d want 4", bus.level); end
    cycle(1'b1, 32'd5, 1'b1);
    n_checks++;
    if (bus.ack !== 1'b1 || bus.dout !== 1 || bus.level !== 3 || bus.wr_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL full_serve got ack=%0b dout=%0d level=%0d wr_ready=%0b want 1 1 3 1", bus.ack, bus.dout, bus.level, bus.wr_ready);
    end
    cycle(1'b1, 32'd5, 1'b1);
    n_checks++;
    if (bus.ack !== 1'b0 || bus.level !== 4) begin n_fail++; $display("FAIL full_fifth_accept got ack=%0b level=%0d want 0 4", bus.ack, bus.level); end
    for (int k = 2; k <= 5; k++) begin
      cycle(1'b0, '0, 1'b1);
      cycle(1'b0, '0, 1'b1);
      n_checks++;
      if (bus.dout !== DW'(k)) begin n_fail++; $display("FAIL full_drain_order got %0d want %0d", bus.dout, k); end
    end
  endtask

  task automatic test_continuous();
    logic [DW-1:0] seen[$];
    do_reset();
    for (int i = 1; i <= 8; i++) begin
      for (int ph = 0; ph < 2; ph++) begin
        cycle(ph == 0, DW'(i), 1'b1);
        n_checks++;
        if (bus.ack !== m_ack) begin n_fail++; $display("FAIL cont_ack word %0d got %0b want %0b", i, bus.ack, m_ack); end
        if (bus.ack === 1'b1) seen.push_back(bus.dout);
      end
    end
    for (int i = 0; i < 4; i++) begin
      cycle(1'b0, '0, 1'b1);
      if (bus.ack === 1'b1) seen.push_back(bus.dout);
    end
    n_checks++;
    if (seen.size() != 8 || bus.count !== 8) begin n_fail++; $display("FAIL cont_total got acks=%0d count=%0d want 8 8", seen.size(), bus.count); end
    for (int i = 0; i < seen.size(); i++) begin
      n_checks++;
      if (seen[i] !== DW'(i + 1)) begin n_fail++; $display("FAIL cont_seq idx %0d got %0d want %0d", i, seen[i], i + 1); end
    end
    bus.req = 1'b0;
  endtask

  task automatic test_wrap();
    do_reset();
    cycle(1'b1, 32'd100, 1'b0);
    cycle(1'b1, 32'd101, 1'b0);
    for (int i = 0; i < 14; i++) begin
      cycle(!m_ack, DW'(102 + i), 1'b1);
      n_checks++;
      if (bus.level !== 2 || bus.ack !== m_ack || (m_ack && bus.dout !== m_dout)) begin
        n_fail++;
        $display("FAIL wrap cycle %0d got level=%0d ack=%0b dout=%0d want 2 %0b %0d", i, bus.level, bus.ack, bus.dout, m_ack, m_dout);
      end
    end
    bus.req = 1'b0;
  endtask

  task automatic test_empty();
    do_reset();
    for (int i = 0; i < 20; i++) begin
      cycle(1'b0, '0, 1'b1);
      n_checks++;
      if (bus.ack !== 1'b0) begin n_fail++; $display("FAIL empty_pending cycle %0d got ack=%0b want 0", i, bus.ack); end
    end
    cycle(1'b1, 32'd77, 1'b1);
    n_checks++;
    if (bus.ack !== 1'b0) begin n_fail++; $display("FAIL empty_push_edge got ack=%0b want 0", bus.ack); end
    cycle(1'b0, '0, 1'b1);
    n_checks++;
    if (bus.ack !== 1'b1 || bus.dout !== 77) begin n_fail++; $display("FAIL empty_serve got ack=%0b dout=%0d want 1 77", bus.ack, bus.dout); end
    bus.req = 1'b0;
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 400; i++) begin
      cycle($urandom_range(0, 2) != 0, $urandom, $urandom_range(0, 3) != 0);
      n_checks++;
      if (bus.ack !== m_ack || bus.dout !== m_dout || bus.level !== m_q.size() ||
          bus.count !== m_count || bus.wr_ready !== (m_q.size() < DEPTH)) begin
        n_fail++;
        $display("FAIL random cycle %0d got ack=%0b dout=%h level=%0d count=%0d wr_ready=%0b want %0b %h %0d %0d %0b",
                 i, bus.ack, bus.dout, bus.level, bus.count, bus.wr_ready,
                 m_ack, m_dout, m_q.size(), m_count, (m_q.size() < DEPTH));
      end
    end
  endtask

  initial begin
    rst = 1'b0;
    bus.wr_valid = 1'b0;
    bus.wr_data  = '0;
    bus.req      = 1'b0;
    model_clear();
    #2;
    n_checks++;
    if (bus.ack !== 1'b0 || bus.level !== 0 || bus.count !== 0 || bus.dout !== 0 || bus.wr_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state got ack=%0b level=%0d count=%0d dout=%h wr_ready=%0b want all 0", bus.ack, bus.level, bus.count, bus.dout, bus.wr_ready);
    end
    test_reset();
    test_single();
    test_full();
    test_continuous();
    test_wrap();
    test_empty();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/arf_push_responder.md
# arf_push_responder

Responder end of the dataflow req/ack handshake: a small synchronous FIFO filled from a push-style (valid/ready) source and drained by any req/ack initiator, such as the consumer or an operator's left port. It answers each request with a single-cycle `ack` plus registered data. It sits at graph boundaries where a streaming source must feed an arf input port (`din_req_N`/`din_ack_N`/`din_N`) in place of the producer model.

## Interface
- `data_width`, 32, payload width.
- `depth`, 4, FIFO entries; power of two, ≥2.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset, asynchronous, active-low.
- `wr_valid`  in  1  source has a word on `wr_data`.
- `wr_ready`  out  1  FIFO can accept a word this cycle.
- `wr_data`  in  data_width  pushed word.
- `req`  in  1  initiator request; held high until it sees `ack`.
- `ack`  out  1  one-cycle pulse; `dout` is valid while `ack`=1.
- `dout`  out  data_width  served word, registered.
- `level`  out  $clog2(depth)+1  current occupancy.
- `count`  out  32  total acks issued; wraps modulo 2^32.

## Operation
- **Storage**
  - Circular buffer with `wr_ptr` and `rd_ptr`, each $clog2(depth) bits and wrapping naturally.
  - `level` is a registered counter, 0..depth.
- **Push side**
  - `wr_ready` = (`level` < depth) and `rst` high. It is combinational from registered `level`.
  - A word is written when `wr_valid & wr_ready` at an edge; then `mem[wr_ptr]` <= `wr_data` and `wr_ptr`++.
- **Serve rule**, evaluated at each edge:
  - If `req & ~ack & (level != 0)`:
    - `ack` <= 1, `dout` <= `mem[rd_ptr]`
    - `rd_ptr`++, `count`++
  - Otherwise `ack` <= 0.
  - `dout` holds its last value when not serving.
- **Level update**
  - write only: +1
  - serve only: −1
  - write and serve in the same cycle: unchanged, with both pointers advancing.
- **No bypass.** A word written at edge N is servable no earlier than edge N+1.
- **Full.** `wr_ready`=0 and no write occurs, even if a serve happens on that edge. `wr_ready` rises on the following cycle.
- **Empty.**
  - `req` is left pending, with no ack and no error.
  - Service starts at the first edge where `level`≠0.
- **Protocol rules**
  - The `~ack` guard forbids back-to-back acks. `req` is typically still high in the ack cycle, and must not produce a second word.
  - `req` falling before service is legal; nothing is consumed.

## Timing
- **Reset values**, applied asynchronously on `rst`=0:
  - `ack`=0, `dout`=0, `level`=0, `count`=0, `wr_ptr`=`rd_ptr`=0
  - `wr_ready`=0 while in reset.
- **Reset mid-operation.** Stored words are discarded and any in-flight ack is cancelled immediately. Memory contents need not be cleared.
- **Latency**
  - push at edge N with `req` high → `ack`=1 after edge N+1.
  - `req` rising with data already present → ack after the next edge.
- **Throughput.** Maximum one word per 2 cycles per requester, matching the initiator side.
- **Ordering.** Strictly FIFO. `dout` during ack k equals the k-th accepted word.

## Structure
- Shared package `arf_pkg`: the clog2-based width helper and the 32-bit `count` width constant, also used by producer/consumer models.
- One natural sub-module, `arf_fifo_store`:
  - contents: memory, pointers, `level`, full/empty flags
  - inputs: write-enable, read-enable
  - read data is combinational from `rd_ptr`.
- The top level holds the serve FSM, which is 2-state: IDLE (`ack`=0) and ACK (`ack`=1). ACK always returns to IDLE on the next edge.
- `dout` and `count` are registered at the top level.

## Test plan
- **Reset.** Assert `rst`=0 mid-ack with `level`=3 → `ack`, `level`, `count`, `dout` go to 0 at once. After release, `wr_ready`=1, and `req` gets no ack until a new push.
- **Single word.** Push 0x0000_00A5 at edge 10 with `req` held high → `ack`=1 only in the cycle after edge 11, `dout`=0xA5, `count`=1, `level` returns to 0.
- **Full.** depth=4: push 1,2,3,4 with `req`=0 → `level`=4 and `wr_ready`=0. A 5th word held on `wr_valid` is not accepted. Raise `req` → first ack returns 1, and the 5th word is accepted the cycle after.
- **Continuous request.**
  - `req` tied high, 8 words prefilled at rate 1/2 → acks at every other cycle.
  - `dout` sequence is 1..8 and is never repeated; `count`=8.
- **Simultaneous push and serve at `level`=2.** `level` stays 2, both pointers wrap past depth−1, and order is preserved across the wrap.
- **Empty with pending request.** `req` high for 20 cycles with `level`=0 → `ack` stays 0. Push at edge 25 → `ack` after edge 26.
